pmem_burst_responder: RTL and testbench
=======================================

PMEM_BURST_RESPONDER -- requirements
Module: pmem_burst_responder

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cache-line width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, meaning DRAM burst beat width; BEATS = LINE_W/BEAT_W = 4.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port pmem_read  in  1  line read request from the L2 cache; held until pmem_resp.
REQ-006 SHALL have port pmem_write  in  1  line write request from the L2 cache; held until pmem_resp.
REQ-007 SHALL have port pmem_address  in  32  line address from the L2 cache.
REQ-008 SHALL have port pmem_wdata  in  LINE_W  write line from the L2 cache.
REQ-009 SHALL have port pmem_rdata  out  LINE_W  assembled read line to the L2 cache.
REQ-010 SHALL have port pmem_resp  out  1  one-cycle completion pulse to the L2 cache.
REQ-011 SHALL have port mem_read  out  1  burst read request to DRAM.
REQ-012 SHALL have port mem_write  out  1  burst write request to DRAM.
REQ-013 SHALL have port mem_address  out  32  line-aligned burst address to DRAM.
REQ-014 SHALL have port mem_wdata  out  BEAT_W  current write beat to DRAM.
REQ-015 SHALL have port mem_rdata  in  BEAT_W  read beat from DRAM, valid when mem_resp=1.
REQ-016 SHALL have port mem_resp  in  1  per-beat DRAM acknowledge.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, DONE and a 2-bit beat counter.
REQ-018 In IDLE with pmem_write=1 SHALL latch pmem_wdata and pmem_address, clear the counter, and enter WRITE next cycle.
REQ-019 In IDLE with pmem_read=1 and pmem_write=0 SHALL latch pmem_address, clear the counter, and enter READ next cycle; when both are 1, write wins.
REQ-020 SHALL drive mem_address = {latched address[31:5], 5'b0} in READ and WRITE, and 0 otherwise.
REQ-021 In READ SHALL assert mem_read=1; each cycle with mem_resp=1 SHALL store mem_rdata into beat[counter] (beat 0 = bits 63:0) and increment the counter.
REQ-022 In WRITE SHALL assert mem_write=1 and drive mem_wdata = latched line beat[counter]; each cycle with mem_resp=1 SHALL increment the counter.
REQ-023 On mem_resp=1 with counter=3 SHALL enter DONE next cycle, deasserting mem_read/mem_write in DONE.
REQ-024 With mem_resp=0 in READ/WRITE, the state and counter SHALL hold; beats need not be consecutive.
REQ-025 In DONE SHALL assert pmem_resp=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-026 Read latency SHALL be measured from IDLE sampling: 1 cycle to READ, then the beat cycles, then 1 DONE cycle; minimum 6 cycles request-to-resp with back-to-back beats.
REQ-027 pmem_rdata SHALL hold the last assembled line from DONE until the next read's first beat overwrites it.
REQ-028 A write SHALL leave pmem_rdata unchanged.
REQ-029 Deassertion of pmem_read/pmem_write mid-burst SHALL NOT abort; the burst completes and pmem_resp still pulses.
REQ-030 mem_resp in IDLE or DONE SHALL be ignored.
REQ-031 pmem_address/pmem_wdata changes after latching SHALL NOT affect the burst in flight.
REQ-032 A request present in IDLE the cycle after DONE SHALL start a new transaction; no idle bubble beyond DONE is required.

Reset
REQ-033 With reset_n=0 at a rising edge SHALL enter IDLE and clear the counter, latched address, latched line and pmem_rdata to 0, in any state including mid-burst.
REQ-034 During and after reset, until a request: pmem_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
REQ-035 After reset release SHALL accept a request on the first edge with reset_n=1.

Verification
REQ-036 Read 0x0000_1234, DRAM beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> mem_address=0x0000_1220; pmem_resp pulses 1 cycle; pmem_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-037 Write 0x0000_2040, line {D3,D2,D1,D0}; DRAM mem_resp with 2-cycle gaps -> mem_wdata steps D0,D1,D2,D3, each held until its mem_resp; pmem_resp only after the 4th beat.
REQ-038 pmem_read=1 and pmem_write=1 together in IDLE -> write burst; pmem_rdata unchanged.
REQ-039 reset_n=0 after beat 2 of a read -> next cycle IDLE, mem_read=0, pmem_rdata=0, no pmem_resp; a subsequent read completes normally.
REQ-040 Spurious mem_resp=1 in IDLE, then a read -> counter starts at 0; beat 0 lands in bits 63:0.
REQ-041 pmem_read dropped after beat 1 -> burst continues to beat 4; pmem_resp=1 for one cycle; back to IDLE.

Source files
------------

// File: rtl/pmem_burst_responder_if.sv
// L2-side line port and DRAM-side burst port of the burst responder.
// slave is the responder's view; master is the environment (L2 + DRAM) view.
interface pmem_burst_responder_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/pmem_burst_responder.sv
// Splits L2 line reads/writes into BEATS DRAM beats; latency 1 + beats + 1 DONE cycle.
// Backpressure: each beat waits for mem_resp; L2 request is held until the pmem_resp pulse.
module pmem_burst_responder #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  pmem_burst_responder_if.slave mif
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [31:0]      ALIGN_MASK = ~32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              beat_ack;
  logic              last_beat;

  // mem_resp outside a burst is a stray acknowledge and must not move anything
  assign beat_ack  = mif.mem_resp && (state_q == READ || state_q == WRITE);
  assign last_beat = beat_ack && (cnt_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mif.pmem_write) begin
          state_d = WRITE;
        end else if (mif.pmem_read) begin
          state_d = READ;
        end
      end
      READ, WRITE: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && (mif.pmem_read || mif.pmem_write)) begin
      cnt_d  = '0;
      addr_d = mif.pmem_address;
      if (mif.pmem_write) begin
        line_d = mif.pmem_wdata;
      end
    end else if (beat_ack) begin
      cnt_d = cnt_q + 1'b1;
      // read line is assembled in place, so it holds until the next read overwrites beat 0
      if (state_q == READ) begin
        rdata_d[int'(cnt_q)*BEAT_W +: BEAT_W] = mif.mem_rdata;
      end
    end
  end

  always_comb begin
    mif.mem_read    = 1'b0;
    mif.mem_write   = 1'b0;
    mif.mem_address = '0;
    mif.mem_wdata   = '0;
    mif.pmem_resp   = 1'b0;
    case (state_q)
      READ: begin
        mif.mem_read    = 1'b1;
        mif.mem_address = addr_q & ALIGN_MASK;
      end
      WRITE: begin
        mif.mem_write   = 1'b1;
        mif.mem_address = addr_q & ALIGN_MASK;
        mif.mem_wdata   = line_q[int'(cnt_q)*BEAT_W +: BEAT_W];
      end
      DONE:    mif.pmem_resp = 1'b1;
      default: ;
    endcase
  end

  assign mif.pmem_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboard bench: driver issues L2 requests, a DRAM model acks beats with random gaps,
// a monitor pops the expected line whenever pmem_resp pulses.
module tb_pmem_burst_responder;
  logic clk;
  logic reset_n;

  pmem_burst_responder_if #(.LINE_W(256), .BEAT_W(64)) mif ();

  pmem_burst_responder #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mif     (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_q [$];
  logic [255:0] model_rdata = '0;

  // current burst as seen by the DRAM model
  logic [63:0] cur_beats [4];
  logic [31:0] cur_maddr;
  bit          cur_wr;
  int          beat_idx  = 0;
  bit          pending   = 0;
  int          wait_cnt  = 0;
  int          fixed_gap = -1;
  int          gap_max   = 0;
  bit          spurious  = 0;

  logic [63:0]  rb [4];
  logic [63:0]  no_beats [4];
  logic [255:0] wline;
  int           lat;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // DRAM model: counts accepted beats, serves read beats, checks write beats are held
  initial begin
    mif.mem_resp  = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pending) beat_idx++;
      pending      = 0;
      mif.mem_resp = 1'b0;
      if (mif.mem_read || mif.mem_write) begin
        chk("mem_address", mif.mem_address, cur_maddr);
        chk("mem_direction", mif.mem_write, cur_wr);
        if (beat_idx > 3) begin
          chk("beat_overrun", beat_idx, 3);
        end else begin
          if (cur_wr) chk("mem_wdata", mif.mem_wdata, cur_beats[beat_idx]);
          if (wait_cnt > 0) begin
            wait_cnt--;
          end else begin
            mif.mem_resp  = 1'b1;
            mif.mem_rdata = cur_wr ? {$urandom, $urandom} : cur_beats[beat_idx];
            pending       = 1;
            wait_cnt      = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(gap_max, 0));
          end
        end
      end else begin
        wait_cnt = 0;
        if (spurious) begin
          mif.mem_resp  = 1'b1;
          mif.mem_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  // monitor: every pmem_resp pulse consumes one expected line
  initial begin
    logic         prev_resp;
    logic [255:0] e;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (mif.pmem_resp === 1'b1) begin
        chk("resp_single_cycle", prev_resp, 1'b0);
        chk("done_mem_quiet", {mif.mem_read, mif.mem_write}, 2'b00);
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", mif.pmem_resp, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("pmem_rdata", mif.pmem_rdata, e);
        end
      end
      prev_resp = mif.pmem_resp;
    end
  end

  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wl, input logic [63:0] rbeats [4],
                         input int drop_after, output int latency);
    bit done;
    bit latched;
    cur_wr    = wr;
    cur_maddr = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < 4; i++) cur_beats[i] = wr ? wl[64*i +: 64] : rbeats[i];
    beat_idx = 0;
    if (!wr) model_rdata = {rbeats[3], rbeats[2], rbeats[1], rbeats[0]};
    exp_q.push_back(model_rdata);
    mif.pmem_read    = rd;
    mif.pmem_write   = wr;
    mif.pmem_address = addr;
    mif.pmem_wdata   = wl;
    latency = 0;
    done    = 0;
    latched = 0;
    while (!done && latency < 400) begin
      tick();
      latency++;
      if (!latched && (mif.mem_read || mif.mem_write)) begin
        latched          = 1;
        mif.pmem_address = $urandom;
        mif.pmem_wdata   = rand_line();
      end
      if (latched && drop_after >= 0 && beat_idx >= drop_after) begin
        mif.pmem_read  = 1'b0;
        mif.pmem_write = 1'b0;
      end
      if (mif.pmem_resp) begin
        done = 1;
        chk("beats_before_resp", beat_idx, 4);
      end
    end
    mif.pmem_read  = 1'b0;
    mif.pmem_write = 1'b0;
    if (!done) begin
      chk("txn_timeout", latency, 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    mif.pmem_read    = 1'b0;
    mif.pmem_write   = 1'b0;
    mif.pmem_address = '0;
    mif.pmem_wdata   = '0;
    for (int i = 0; i < 4; i++) no_beats[i] = '0;
    repeat (3) tick();
    chk("rst_pmem_resp", mif.pmem_resp, 1'b0);
    chk("rst_mem_read", mif.mem_read, 1'b0);
    chk("rst_mem_write", mif.mem_write, 1'b0);
    chk("rst_mem_address", mif.mem_address, 32'h0);
    chk("rst_mem_wdata", mif.mem_wdata, 64'h0);
    chk("rst_pmem_rdata", mif.pmem_rdata, 256'h0);

    // request presented together with reset release; back-to-back beats
    reset_n = 1'b1;
    rb[0] = 64'h1111_1111_1111_1111;
    rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333;
    rb[3] = 64'h4444_4444_4444_4444;
    run_txn(1, 0, 32'h0000_1234, '0, rb, -1, lat);
    chk("read_latency", lat, 5);
    chk("read_line_held", mif.pmem_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // write with two idle cycles between acknowledges
    fixed_gap = 2;
    wline = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
             64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    run_txn(0, 1, 32'h0000_2040, wline, no_beats, -1, lat);
    fixed_gap = -1;
    chk("write_keeps_rdata", mif.pmem_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // read and write together: write wins
    for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
    run_txn(1, 1, 32'h0000_3000, rand_line(), rb, -1, lat);
    chk("both_write_wins_rdata", mif.pmem_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // reset after two beats of a read
    for (int i = 0; i < 4; i++) cur_beats[i] = {$urandom, $urandom};
    cur_wr = 0; cur_maddr = 32'h0000_5000; beat_idx = 0;
    mif.pmem_read = 1'b1; mif.pmem_address = 32'h0000_5008;
    for (int t = 0; t < 50 && beat_idx < 2; t++) tick();
    chk("mid_reset_reached_beat2", beat_idx, 2);
    reset_n = 1'b0;
    mif.pmem_read = 1'b0;
    tick();
    chk("mid_reset_mem_read", mif.mem_read, 1'b0);
    chk("mid_reset_mem_address", mif.mem_address, 32'h0);
    chk("mid_reset_pmem_rdata", mif.pmem_rdata, 256'h0);
    chk("mid_reset_pmem_resp", mif.pmem_resp, 1'b0);
    reset_n = 1'b1;
    model_rdata = '0;
    tick();
    beat_idx = 0;
    for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
    gap_max = 1;
    run_txn(1, 0, 32'h0000_6010, '0, rb, -1, lat);

    // stray acknowledges while idle, then a read
    tick();
    spurious = 1;
    repeat (3) tick();
    spurious = 0;
    for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
    run_txn(1, 0, 32'h0000_7000, '0, rb, -1, lat);
    chk("spurious_beat0_low", mif.pmem_rdata[63:0], rb[0]);

    // read request dropped after the first beat
    for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
    run_txn(1, 0, 32'h0000_8020, '0, rb, 1, lat);
    tick();
    chk("drop_back_idle", {mif.mem_read, mif.mem_write, mif.pmem_resp}, 3'b000);

    // randomized traffic, including back-to-back requests
    for (int n = 0; n < 40; n++) begin
      int kind;
      int drop;
      kind    = $urandom_range(2, 0);
      gap_max = $urandom_range(3, 0);
      drop    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      for (int i = 0; i < 4; i++) rb[i] = {$urandom, $urandom};
      run_txn(kind != 1, kind != 0, $urandom, rand_line(), rb, drop, lat);
      repeat ($urandom_range(2, 0)) tick();
    end

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
